// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-port memory arbiter
// Contents:
//   state_t  : arbiter FSM states (IDLE, ACCESS, RESP)
//   req_id_t : requester identity (REQ_CPU=0, REQ_DBG=1)
// Build option: MEM_ARB_ROUND_ROBIN_EN (consumed by arb_pick and mem_arbiter)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_t;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner selection between CPU and DBG
// Ports:
//   cpu_req, dbg_req : raw request lines
//   ptr              : last-served requester (round-robin history)
//   winner           : requester to grant when any request is high
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin, otherwise CPU
//   has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic    cpu_req,
    input  logic    dbg_req,
    input  req_id_t ptr,
    output req_id_t winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention the port that was not served last wins.
    always_comb begin
        winner = REQ_CPU;
        if (cpu_req && dbg_req) begin
            winner = (ptr == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (dbg_req) begin
            winner = REQ_DBG;
        end else begin
            winner = REQ_CPU;
        end
    end
`else
    // Fixed priority. With no request the result is ignored by the caller;
    // returning ptr there keeps the port meaningful in both builds.
    always_comb begin
        winner = ptr;
        if (cpu_req) begin
            winner = REQ_CPU;
        end else if (dbg_req) begin
            winner = REQ_DBG;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/debug arbiter in front of a single-port RAM
// Ports:
//   clk_100M, rst (sync, active-high), clk_en (advance strobe)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ack/cpu_rdata : CPU port
//   dbg_req/dbg_we/dbg_addr/dbg_wdata -> dbg_ack/dbg_rdata : debug/loader port
//   wr_en/mem_addr/w_data -> RAM, r_data <- RAM (one tick read latency)
//   busy (not IDLE), owner (0=CPU, 1=DBG)
// Build option: MEM_ARB_ROUND_ROBIN_EN enables round-robin on contention;
//   without it the CPU has fixed priority and no pointer flop exists.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)
(
    input  logic          clk_100M,
    input  logic          rst,
    input  logic          clk_en,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,

    output logic          wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] w_data,
    input  logic [DW-1:0] r_data,

    output logic          busy,
    output logic          owner
);

    state_t  state;
    req_id_t owner_q;
    req_id_t winner;
    req_id_t rr_ptr;
    logic    lat_we;
    logic    any_req;
    logic    grant;

    assign any_req = cpu_req | dbg_req;
    assign grant   = clk_en && (state == IDLE) && any_req;

    arb_pick u_arb_pick (
        .cpu_req (cpu_req),
        .dbg_req (dbg_req),
        .ptr     (rr_ptr),
        .winner  (winner)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Pointer remembers the last grant; resetting it to DBG lets the CPU
    // win the first contention after reset.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            rr_ptr <= REQ_DBG;
        end else if (grant) begin
            rr_ptr <= winner;
        end
    end
`else
    assign rr_ptr = REQ_CPU;
`endif

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state     <= IDLE;
            owner_q   <= REQ_CPU;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            w_data    <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
        end else begin
            // Acks are single clk_100M pulses, cleared even when clk_en is low.
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            if (clk_en) begin
                case (state)
                    IDLE: begin
                        if (any_req) begin
                            owner_q <= winner;
                            if (winner == REQ_DBG) begin
                                lat_we   <= dbg_we;
                                mem_addr <= dbg_addr;
                                w_data   <= dbg_wdata;
                            end else begin
                                lat_we   <= cpu_we;
                                mem_addr <= cpu_addr;
                                w_data   <= cpu_wdata;
                            end
                            state <= ACCESS;
                        end
                    end
                    ACCESS: begin
                        state <= RESP;
                    end
                    RESP: begin
                        // r_data now reflects the address presented in ACCESS.
                        if (owner_q == REQ_DBG) begin
                            dbg_ack <= 1'b1;
                            if (!lat_we) begin
                                dbg_rdata <= r_data;
                            end
                        end else begin
                            cpu_ack <= 1'b1;
                            if (!lat_we) begin
                                cpu_rdata <= r_data;
                            end
                        end
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_en = (state == ACCESS) && lat_we;
    assign busy  = (state != IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_100M = 1'b0;
    logic          rst      = 1'b1;
    logic          clk_en   = 1'b1;
    logic          cpu_req  = 1'b0;
    logic          cpu_we   = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req  = 1'b0;
    logic          dbg_we   = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] w_data;
    logic [DW-1:0] r_data;
    logic          busy;
    logic          owner;

    int n_checks = 0;
    int n_fail   = 0;
    int en_div   = 1;
    int cyc      = 0;

    logic          ram_load = 1'b0;
    logic [7:0]    ram_load_addr = '0;
    logic [DW-1:0] ram_load_data = '0;
    logic [DW-1:0] ram [256];

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_100M  (clk_100M),
        .rst       (rst),
        .clk_en    (clk_en),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .wr_en     (wr_en),
        .mem_addr  (mem_addr),
        .w_data    (w_data),
        .r_data    (r_data),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk_100M = ~clk_100M;

    // RAM model: registered read, one tick after the address is presented.
    always @(posedge clk_100M) begin
        if (ram_load) begin
            ram[ram_load_addr] <= ram_load_data;
        end else if (clk_en) begin
            if (wr_en) ram[mem_addr[7:0]] <= w_data;
            r_data <= ram[mem_addr[7:0]];
        end
    end

    // clk_en generator: high on every en_div-th cycle.
    initial begin
        forever begin
            @(negedge clk_100M);
            cyc++;
            clk_en = ((cyc % en_div) == 0);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_ram(input logic [7:0] a, input logic [DW-1:0] d);
        @(negedge clk_100M);
        ram_load_addr = a;
        ram_load_data = d;
        ram_load      = 1'b1;
        @(negedge clk_100M);
        ram_load      = 1'b0;
    endtask

    // One transaction on one port; returns tick count up to the ack,
    // cycles with wr_en high, cycles with busy high, and ack observations.
    task automatic xfer(input bit is_dbg, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int ticks, output int wr_cyc,
                        output int busy_cyc, output bit got_ack, output bit other_ack);
        @(negedge clk_100M);
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
        ticks = 0; wr_cyc = 0; busy_cyc = 0; got_ack = 1'b0; other_ack = 1'b0;
        for (int i = 0; i < 200 && !got_ack; i++) begin
            @(posedge clk_100M);
            if (clk_en) ticks++;
            @(negedge clk_100M);
            if (wr_en) wr_cyc++;
            if (busy) busy_cyc++;
            if (is_dbg ? cpu_ack : dbg_ack) other_ack = 1'b1;
            if (is_dbg ? dbg_ack : cpu_ack) got_ack = 1'b1;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    int ticks, wr_cyc, busy_cyc, ack_cnt, n_got;
    bit got_ack, other_ack;
    logic [1:0] order [4];
    logic [1:0] exp_order [4];

    initial begin
        load_ram(8'h10, 32'hDEADBEEF);
        repeat (2) @(negedge clk_100M);

        // Reset state
        check_eq("rst_busy",      busy,      0);
        check_eq("rst_owner",     owner,     0);
        check_eq("rst_wr_en",     wr_en,     0);
        check_eq("rst_cpu_ack",   cpu_ack,   0);
        check_eq("rst_dbg_ack",   dbg_ack,   0);
        check_eq("rst_mem_addr",  mem_addr,  0);
        check_eq("rst_w_data",    w_data,    0);
        check_eq("rst_cpu_rdata", cpu_rdata, 0);
        check_eq("rst_dbg_rdata", dbg_rdata, 0);
        rst = 1'b0;

        // CPU read of 0x10
        xfer(0, 0, 32'h10, 0, ticks, wr_cyc, busy_cyc, got_ack, other_ack);
        check_eq("rd_ack",       got_ack,   1);
        check_eq("rd_latency",   ticks - 1, 2);
        check_eq("rd_wr_en",     wr_cyc,    0);
        check_eq("rd_dbg_ack",   other_ack, 0);
        check_eq("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check_eq("rd_dbg_rdata", dbg_rdata, 0);
        check_eq("rd_owner",     owner,     0);
        @(negedge clk_100M);
        check_eq("rd_ack_width", cpu_ack,   0);

        // DBG write 0x12345678 to 0x40, then CPU read back
        xfer(1, 1, 32'h40, 32'h12345678, ticks, wr_cyc, busy_cyc, got_ack, other_ack);
        check_eq("wr_ack",        got_ack,   1);
        check_eq("wr_wr_en_cyc",  wr_cyc,    1);
        check_eq("wr_cpu_ack",    other_ack, 0);
        check_eq("wr_owner",      owner,     1);
        check_eq("wr_addr_hold",  mem_addr,  32'h40);
        check_eq("wr_data_hold",  w_data,    32'h12345678);
        check_eq("wr_rdata_hold", cpu_rdata, 32'hDEADBEEF);
        xfer(0, 0, 32'h40, 0, ticks, wr_cyc, busy_cyc, got_ack, other_ack);
        check_eq("rb_cpu_rdata",  cpu_rdata, 32'h12345678);

        // cpu_req dropped during RESP
        @(negedge clk_100M);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        @(negedge clk_100M);
        @(negedge clk_100M);
        cpu_req = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_100M);
            if (cpu_ack) ack_cnt++;
        end
        check_eq("drop_ack_cnt", ack_cnt,   1);
        check_eq("drop_busy",    busy,      0);
        check_eq("drop_rdata",   cpu_rdata, 32'hDEADBEEF);

        // clk_en every 4th cycle
        en_div = 4;
        xfer(0, 0, 32'h40, 0, ticks, wr_cyc, busy_cyc, got_ack, other_ack);
        check_eq("slow_ack",     got_ack,   1);
        check_eq("slow_latency", ticks - 1, 2);
        check_eq("slow_busy",    busy_cyc,  8);
        check_eq("slow_rdata",   cpu_rdata, 32'h12345678);
        @(negedge clk_100M);
        check_eq("slow_ack_width", cpu_ack, 0);
        en_div = 1;
        repeat (4) @(negedge clk_100M);

        // Reset during ACCESS of a DBG write
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = 32'hA5A5A5A5;
        for (int i = 0; i < 10 && !busy; i++) @(negedge clk_100M);
        check_eq("abort_in_access", wr_en, 1);
        rst = 1'b1; dbg_req = 1'b0;
        @(negedge clk_100M);
        rst = 1'b0;
        check_eq("abort_busy",  busy,    0);
        check_eq("abort_wr_en", wr_en,   0);
        ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (dbg_ack) ack_cnt++;
            @(negedge clk_100M);
        end
        check_eq("abort_no_ack", ack_cnt,   0);
        check_eq("abort_rdata",  cpu_rdata, 0);

        // Contention for 4 transactions, straight after reset
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
        exp_order = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
        order = '{2'd3, 2'd3, 2'd3, 2'd3};
        n_got = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
        for (int i = 0; i < 60 && n_got < 4; i++) begin
            @(negedge clk_100M);
            if (cpu_ack) begin order[n_got] = 2'd0; n_got++; end
            else if (dbg_ack) begin order[n_got] = 2'd1; n_got++; end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        check_eq("arb_count", n_got, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("arb_grant%0d", i), order[i], exp_order[i]);
        end
        repeat (4) @(negedge clk_100M);
        check_eq("arb_idle",  busy,      0);
        check_eq("arb_rdata", cpu_rdata, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
